// File: rtl/pipe_stage_elastic.sv
// Decode-to-execute pipeline register with ready/valid handshakes on both sides.
// The stage holds a main entry that drives the execute side. An optional skid
// entry lets the stage register in_ready, so decode never sees a combinational
// path from out_ready. Flush either empties the stage or leaves one NOP bubble.
module pipe_stage_elastic #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] NOP_IR       = 32'h00000013,
    parameter bit          SKID         = 1'b1,
    parameter bit          FLUSH_BUBBLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [31:0]     in_ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [31:0]     out_ir,
    output logic [1:0]      occ
);

    // Payload is carried as one flat vector: {pc, rs1, rs2, imm, ir}.
    localparam int PW = 4 * XLEN + 32;
    localparam logic [PW-1:0] BUBBLE = {{(4 * XLEN){1'b0}}, NOP_IR};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic [PW-1:0]   in_bus;
    logic            in_ready_q;
    logic            valid_i;
    logic            in_fire;
    logic            out_fire;

    assign in_bus   = {in_pc, in_rs1, in_rs2, in_imm, in_ir};
    assign valid_i  = (state != EMPTY);

    // With a skid entry in_ready comes straight from a flop; without one the
    // stage can only accept when main is empty or draining this cycle.
    assign in_ready = SKID ? in_ready_q : (!valid_i || out_ready);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_i && out_ready;

    assign out_valid = valid_i;
    assign occ       = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
    assign {out_pc, out_rs1, out_rs2, out_imm, out_ir} = main_q;

    // Occupancy state machine, payload registers and registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            in_ready_q <= 1'b1;
            if (FLUSH_BUBBLE) begin
                state  <= ONE;
                main_q <= BUBBLE;
            end else begin
                state  <= EMPTY;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_q <= in_bus;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_bus;
                    end else if (in_fire) begin
                        if (SKID) begin
                            state      <= FULL;
                            skid_q     <= in_bus;
                            in_ready_q <= 1'b0;
                        end
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state      <= ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic. Three instances share one
// stimulus stream: 0 = skid + bubble, 1 = skid + drop, 2 = no skid + bubble.
// A queue-style reference model per instance is checked every cycle; a
// hand-built vector table additionally pins down instance 0.
module tb_pipe_stage_elastic;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] ir;
    } pay_t;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          iv;
        bit          ordy;
        bit          chk;
        logic [31:0] pc;
        bit          ev;
        bit          er;
        int          eocc;
        logic [31:0] epc;
        logic [31:0] eir;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [31:0] in_ir;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic [1:0]  occ_w       [3];
    logic [31:0] out_pc_w    [3];
    logic [31:0] out_rs1_w   [3];
    logic [31:0] out_rs2_w   [3];
    logic [31:0] out_imm_w   [3];
    logic [31:0] out_ir_w    [3];

    int vectors = 0;
    int miscompares = 0;

    // reference model: up to two queued payloads per instance plus the value
    // last shown on the outputs
    pay_t m [3][2];
    int   cnt [3];
    pay_t held [3];
    bit   armed = 1'b0;

    vec_t tbl [22];

    // free-running clock
    always #5 clk = ~clk;

    pipe_stage_elastic #(.SKID(1'b1), .FLUSH_BUBBLE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_ir(in_ir),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_pc(out_pc_w[0]), .out_rs1(out_rs1_w[0]), .out_rs2(out_rs2_w[0]),
        .out_imm(out_imm_w[0]), .out_ir(out_ir_w[0]), .occ(occ_w[0])
    );

    pipe_stage_elastic #(.SKID(1'b1), .FLUSH_BUBBLE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_ir(in_ir),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_pc(out_pc_w[1]), .out_rs1(out_rs1_w[1]), .out_rs2(out_rs2_w[1]),
        .out_imm(out_imm_w[1]), .out_ir(out_ir_w[1]), .occ(occ_w[1])
    );

    pipe_stage_elastic #(.SKID(1'b0), .FLUSH_BUBBLE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_ir(in_ir),
        .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .out_pc(out_pc_w[2]), .out_rs1(out_rs1_w[2]), .out_rs2(out_rs2_w[2]),
        .out_imm(out_imm_w[2]), .out_ir(out_ir_w[2]), .occ(occ_w[2])
    );

    function automatic pay_t pay_of(input logic [31:0] pc);
        pay_t p;
        p.pc  = pc;
        p.rs1 = pc + 32'h11;
        p.rs2 = ~pc;
        p.imm = pc << 2;
        p.ir  = {pc[15:0], 16'h0033};
        return p;
    endfunction

    function automatic logic [31:0] irof(input logic [31:0] pc);
        pay_t p;
        p = pay_of(pc);
        return p.ir;
    endfunction

    function automatic vec_t mk(input bit r, input bit f, input bit iv, input bit o,
                                input bit chk, input logic [31:0] pc, input bit ev,
                                input bit er, input int eocc, input logic [31:0] epc,
                                input logic [31:0] eir);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = o; v.chk = chk; v.pc = pc;
        v.ev = ev; v.er = er; v.eocc = eocc; v.epc = epc; v.eir = eir;
        return v;
    endfunction

    function automatic bit skid_of(input int d);
        return d != 2;
    endfunction

    function automatic bit fb_of(input int d);
        return d != 1;
    endfunction

    function automatic bit mdl_ready(input int d);
        if (skid_of(d)) return cnt[d] < 2;
        return (cnt[d] == 0) || (out_ready == 1'b1);
    endfunction

    function automatic pay_t mdl_out(input int d);
        return (cnt[d] > 0) ? m[d][0] : held[d];
    endfunction

    task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit f, input bit iv, input bit o, input pay_t p);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = o;
        in_pc     = p.pc;
        in_rs1    = p.rs1;
        in_rs2    = p.rs2;
        in_imm    = p.imm;
        in_ir     = p.ir;
    endtask

    // compares every instance against the model's view of the current cycle
    task automatic checkOutput();
        pay_t ep;
        for (int d = 0; d < 3; d++) begin
            ep = mdl_out(d);
            cmp($sformatf("in_ready[%0d]", d), in_ready_w[d], mdl_ready(d));
            cmp($sformatf("out_valid[%0d]", d), out_valid_w[d], cnt[d] > 0);
            cmp($sformatf("occ[%0d]", d), occ_w[d], cnt[d][1:0]);
            cmp($sformatf("payload[%0d]", d),
                {out_pc_w[d], out_rs1_w[d], out_rs2_w[d], out_imm_w[d], out_ir_w[d]}, ep);
        end
    endtask

    task automatic checkRow(input int i);
        cmp($sformatf("row%0d out_valid", i), out_valid_w[0], tbl[i].ev);
        cmp($sformatf("row%0d in_ready", i), in_ready_w[0], tbl[i].er);
        cmp($sformatf("row%0d occ", i), occ_w[0], tbl[i].eocc[1:0]);
        cmp($sformatf("row%0d out_pc", i), out_pc_w[0], tbl[i].epc);
        cmp($sformatf("row%0d out_ir", i), out_ir_w[0], tbl[i].eir);
    endtask

    // advances the model across the coming clock edge using the driven inputs
    task automatic modelEdge();
        pay_t bub;
        bit   ifire;
        bit   ofire;
        bub    = '0;
        bub.ir = 32'h00000013;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                cnt[d]  = 0;
                held[d] = '0;
            end else if (flush) begin
                if (fb_of(d)) begin
                    m[d][0] = bub;
                    cnt[d]  = 1;
                end else begin
                    cnt[d]  = 0;
                end
            end else begin
                ifire = in_valid && mdl_ready(d);
                ofire = (cnt[d] > 0) && out_ready;
                if (ofire) begin
                    m[d][0] = m[d][1];
                    cnt[d]--;
                end
                if (ifire) begin
                    m[d][cnt[d]] = {in_pc, in_rs1, in_rs2, in_imm, in_ir};
                    cnt[d]++;
                end
            end
            if (cnt[d] > 0) held[d] = m[d][0];
        end
    endtask

    task automatic advance();
        modelEdge();
        @(posedge clk);
        if (rst) armed = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int vcount [3];
        pay_t rp;

        for (int d = 0; d < 3; d++) begin
            cnt[d]  = 0;
            held[d] = '0;
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0);
        tbl[2]  = mk(0, 0, 1, 1, 1, 32'h100, 0, 1, 0, 32'h0,   32'h0);
        tbl[3]  = mk(0, 0, 1, 1, 1, 32'h104, 1, 1, 1, 32'h100, irof(32'h100));
        tbl[4]  = mk(0, 0, 1, 1, 1, 32'h108, 1, 1, 1, 32'h104, irof(32'h104));
        tbl[5]  = mk(0, 0, 0, 1, 1, 32'h0,   1, 1, 1, 32'h108, irof(32'h108));
        tbl[6]  = mk(0, 0, 1, 0, 1, 32'h200, 0, 1, 0, 32'h108, irof(32'h108));
        tbl[7]  = mk(0, 0, 1, 0, 1, 32'h204, 1, 1, 1, 32'h200, irof(32'h200));
        tbl[8]  = mk(0, 0, 1, 0, 1, 32'h208, 1, 0, 2, 32'h200, irof(32'h200));
        tbl[9]  = mk(0, 0, 0, 1, 1, 32'h0,   1, 0, 2, 32'h200, irof(32'h200));
        tbl[10] = mk(0, 0, 1, 1, 1, 32'h208, 1, 1, 1, 32'h204, irof(32'h204));
        tbl[11] = mk(0, 0, 0, 1, 1, 32'h0,   1, 1, 1, 32'h208, irof(32'h208));
        tbl[12] = mk(0, 0, 1, 0, 1, 32'h400, 0, 1, 0, 32'h208, irof(32'h208));
        tbl[13] = mk(0, 0, 1, 0, 1, 32'h404, 1, 1, 1, 32'h400, irof(32'h400));
        tbl[14] = mk(0, 1, 1, 0, 1, 32'h300, 1, 0, 2, 32'h400, irof(32'h400));
        tbl[15] = mk(0, 0, 0, 0, 1, 32'h0,   1, 1, 1, 32'h0,   32'h13);
        tbl[16] = mk(0, 0, 0, 1, 1, 32'h0,   1, 1, 1, 32'h0,   32'h13);
        tbl[17] = mk(0, 0, 0, 0, 1, 32'h0,   0, 1, 0, 32'h0,   32'h13);
        tbl[18] = mk(0, 0, 1, 0, 1, 32'h500, 0, 1, 0, 32'h0,   32'h13);
        tbl[19] = mk(0, 0, 1, 0, 1, 32'h504, 1, 1, 1, 32'h500, irof(32'h500));
        tbl[20] = mk(1, 1, 0, 0, 1, 32'h0,   1, 0, 2, 32'h500, irof(32'h500));
        tbl[21] = mk(0, 0, 0, 0, 1, 32'h0,   0, 1, 0, 32'h0,   32'h0);

        // directed scenarios: stream, backpressure, flush, reset over flush
        for (int i = 0; i < 22; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy, pay_of(tbl[i].pc));
            #1;
            if (armed) checkOutput();
            if (tbl[i].chk) checkRow(i);
            advance();
        end

        // simultaneous accept and drain: one transfer per cycle, occupancy 1
        vcount[0] = 0; vcount[1] = 0; vcount[2] = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, pay_of(32'h600 + 32'(4 * i)));
            #1;
            checkOutput();
            if (i > 0) begin
                for (int d = 0; d < 3; d++)
                    if (out_valid_w[d] === 1'b1 && occ_w[d] === 2'd1) vcount[d]++;
            end
            advance();
        end
        cmp("throughput skid", 32'(vcount[0]), 32'd8);
        cmp("throughput noskid", 32'(vcount[2]), 32'd8);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            rp.pc  = $urandom;
            rp.rs1 = $urandom;
            rp.rs2 = $urandom;
            rp.imm = $urandom;
            rp.ir  = $urandom;
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rp);
            #1;
            checkOutput();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
